// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 100 MHz UART IP. Both the receiver and the
// transmitter use this package, so they agree on the bit period.
//   - uart_state_t : receiver frame state encoding
//   - CNT_W        : width of the bit-period counter
//   - baud_count() : baud select -> terminal count N (bit period is N+1 cycles)
//   - half_count() : mid-bit offset H = N>>1 used to qualify the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CNT_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // Terminal counts for a 100 MHz clock. Index 000 is the slowest rate.
    function automatic logic [CNT_W-1:0] baud_count(input logic [2:0] sel);
        logic [CNT_W-1:0] n;
        case (sel)
            3'b000:  n = 14'd10416;
            3'b001:  n = 14'd5208;
            3'b010:  n = 14'd2604;
            3'b011:  n = 14'd1736;
            3'b100:  n = 14'd868;
            3'b101:  n = 14'd434;
            3'b110:  n = 14'd217;
            default: n = 14'd108;
        endcase
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] half_count(input logic [CNT_W-1:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous, idle-high input. Both
// stages reset to 1 so that an idle line is not mistaken for an edge when
// reset is released.
// Ports:
//   clock    in  system clock
//   resetn   in  synchronous active-low reset
//   async_in in  asynchronous input
//   sync_out out synchronized copy of async_in, 2 cycles of latency
// -----------------------------------------------------------------------------
module uart_sync2 (
    input  logic clock,
    input  logic resetn,
    input  logic async_in,
    output logic sync_out
);

    logic meta_p0;

    // Stage p0 catches the metastable sample, p1 (sync_out) resolves it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta_p0  <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta_p0  <= async_in;
            sync_out <= meta_p0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8 data bits LSB-first, one stop bit, no parity. The RX pin is
// synchronized, the start bit is re-checked at mid-bit, data and stop bits are
// sampled at bit centres, and the byte is handed to the register block through
// a sticky ready flag cleared by rx_clr.
// Ports:
//   clock       in   100 MHz system clock
//   resetn      in   synchronous active-low reset
//   uart_en     in   receiver enable; low aborts any frame in progress
//   baud_rx_sel in   baud select (see uart_pkg::baud_count)
//   RX          in   asynchronous serial input, idle high
//   rx_clr      in   one-cycle pulse: byte consumed by software
//   rx_data     out  last good byte
//   rx_done     out  one-cycle pulse when a good byte lands in rx_data
//   rx_ready    out  sticky: unread byte present
//   overrun     out  sticky: good byte arrived while rx_ready was set
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   rx_busy     out  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx (
    input  logic       clock,
    input  logic       resetn,
    input  logic       uart_en,
    input  logic [2:0] baud_rx_sel,
    input  logic       RX,
    input  logic       rx_clr,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       rx_busy
);

    import uart_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic             rx_s;
    logic             rx_d;
    logic             start_edge;

    uart_state_t      state;
    uart_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic [CNT_W-1:0] baud_n;
    logic [CNT_W-1:0] half_n;
    logic             load_byte;
    logic             frame_bad;

    // Synchronizer stage: pin to rx_s is two cycles.
    uart_sync2 u_sync (
        .clock    (clock),
        .resetn   (resetn),
        .async_in (RX),
        .sync_out (rx_s)
    );

    // Edge-detect stage: rx_d is the previous rx_s. A start is a 1->0
    // transition, so a line held low never restarts a frame.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rx_d <= 1'b1;
        end else begin
            rx_d <= rx_s;
        end
    end

    assign start_edge = rx_d & ~rx_s;

    // The compare values follow baud_rx_sel directly, so a change takes
    // effect at the next compare.
    assign baud_n = baud_count(baud_rx_sel);
    assign half_n = half_count(baud_n);

    // Frame FSM: next-state, counters and sample decisions.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_ONE;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        load_byte   = 1'b0;
        frame_bad   = 1'b0;

        if (!uart_en) begin
            state_nxt   = IDLE;
            cnt_nxt     = CNT_ZERO;
            bit_cnt_nxt = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = CNT_ZERO;
                    if (start_edge) begin
                        state_nxt = START;
                    end
                end

                // Re-check the start bit half a period in; a line that has
                // gone high again was only a glitch.
                START: begin
                    if (cnt == half_n) begin
                        cnt_nxt = CNT_ZERO;
                        if (!rx_s) begin
                            state_nxt   = DATA;
                            bit_cnt_nxt = 3'd0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end

                // Shifting in at the top and moving right leaves the first
                // received bit in bit 0 after eight samples.
                DATA: begin
                    if (cnt == baud_n) begin
                        cnt_nxt   = CNT_ZERO;
                        shreg_nxt = {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (cnt == baud_n) begin
                        cnt_nxt   = CNT_ZERO;
                        state_nxt = IDLE;
                        if (rx_s) begin
                            load_byte = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= CNT_ZERO;
            bit_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Shift register contents are only meaningful once eight bits have been
    // shifted in, so it carries no reset.
    always_ff @(posedge clock) begin
        shreg <= shreg_nxt;
    end

    // Output register stage: everything here becomes visible in the first
    // IDLE cycle after the stop-bit sample. A byte landing together with
    // rx_clr counts as the new unread byte, so ready stays set and overrun
    // is cleared.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= load_byte;
            frame_err <= frame_bad;
            if (load_byte) begin
                rx_data  <= shreg;
                rx_ready <= 1'b1;
                overrun  <= rx_clr ? 1'b0 : (overrun | rx_ready);
            end else if (rx_clr) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
// Randomized self-checking bench for uart_rx. A serial driver produces frames
// at an exact bit period; a high-level model tracks the bytes and flag state
// the receiver should end up with.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_en = 1'b0;
    logic [2:0] baud_rx_sel = 3'b111;
    logic       RX = 1'b1;
    logic       rx_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_ready;
    logic       overrun;
    logic       frame_err;
    logic       rx_busy;

    uart_rx dut (
        .clock       (clock),
        .resetn      (resetn),
        .uart_en     (uart_en),
        .baud_rx_sel (baud_rx_sel),
        .RX          (RX),
        .rx_clr      (rx_clr),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed events.
    logic [7:0]  got_q[$];
    int          ferr_seen = 0;
    int unsigned last_done_cyc = 0;
    int unsigned last_st = 0;

    // Reference model state.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_ready = 1'b0;
    logic       exp_overrun = 1'b0;

    always @(negedge clock) begin
        if (rx_done) begin
            got_q.push_back(rx_data);
            last_done_cyc = cyc;
        end
        if (frame_err) ferr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input logic [2:0] sel);
        case (sel)
            3'b000:  return 10416;
            3'b001:  return 5208;
            3'b010:  return 2604;
            3'b011:  return 1736;
            3'b100:  return 868;
            3'b101:  return 434;
            3'b110:  return 217;
            default: return 108;
        endcase
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB-first, stop bit; RX is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int n);
        logic [9:0] bits;
        bits    = {stop, b, 1'b0};
        last_st = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = bits[i];
            idle(n + 1);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic clr_same);
        if (stop) begin
            exp_q.push_back(b);
            exp_data = b;
            if (clr_same) exp_overrun = 1'b0;
            else if (exp_ready) exp_overrun = 1'b1;
            exp_ready = 1'b1;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic pulse_clr();
        rx_clr = 1'b1;
        idle(1);
        rx_clr = 1'b0;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, " done count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, " byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, " rx_data"}, rx_data, exp_data);
        chk({tag, " rx_ready"}, rx_ready, exp_ready);
        chk({tag, " overrun"}, overrun, exp_overrun);
        chk({tag, " frame_err count"}, ferr_seen, exp_ferr);
        chk({tag, " rx_busy"}, rx_busy, 1'b0);
    endtask

    initial begin
        int         n;
        int         lat;
        logic [7:0] b;
        logic       stop;

        idle(3);
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset rx_done", rx_done, 1'b0);
        chk("reset rx_ready", rx_ready, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset rx_busy", rx_busy, 1'b0);
        resetn  = 1'b1;
        uart_en = 1'b1;
        idle(10);

        // Good frame and end-to-end latency: 2 sync + 1 detect + 1036.
        n = n_of(3'b111);
        send_frame(8'hA5, 1'b1, n);
        model_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        lat = 3 + (n / 2 + 1) + 9 * (n + 1);
        chk("good latency", last_done_cyc - last_st, lat);
        check_state("good");

        // Framing error, then a line stuck low must not start a frame.
        send_frame(8'h3C, 1'b0, n);
        model_frame(8'h3C, 1'b0, 1'b0);
        idle(500);
        chk("stuck low busy", rx_busy, 1'b0);
        RX = 1'b1;
        idle(20);
        check_state("frame_err");

        // 30-cycle glitch.
        RX = 1'b0;
        idle(10);
        chk("glitch busy", rx_busy, 1'b1);
        idle(20);
        RX = 1'b1;
        idle(60);
        check_state("glitch");

        // Overrun, then clear.
        send_frame(8'h11, 1'b1, n);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, n);
        model_frame(8'h22, 1'b1, 1'b0);
        idle(20);
        check_state("overrun");
        pulse_clr();
        idle(2);
        check_state("clr");

        // rx_clr coincident with the second byte landing.
        send_frame(8'h33, 1'b1, n);
        model_frame(8'h33, 1'b1, 1'b0);
        fork
            send_frame(8'h44, 1'b1, n);
            begin
                idle(lat - 1);
                rx_clr = 1'b1;
                idle(1);
                rx_clr = 1'b0;
            end
        join
        model_frame(8'h44, 1'b1, 1'b1);
        idle(20);
        check_state("clr coincident");

        // Abort mid-DATA, then a clean frame.
        fork
            send_frame(8'($urandom), 1'b1, n);
            begin
                idle(55 + 3 * (n + 1) + 40);
                chk("abort busy before", rx_busy, 1'b1);
                uart_en = 1'b0;
                idle(1);
                chk("abort busy after", rx_busy, 1'b0);
            end
        join
        idle(10);
        uart_en = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b1, n);
        model_frame(8'h5A, 1'b1, 1'b0);
        idle(20);
        check_state("abort");

        // Randomized frames at the two fastest rates.
        for (int i = 0; i < 6; i++) begin
            baud_rx_sel = 3'($urandom_range(6, 7));
            n    = n_of(baud_rx_sel);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, n);
            model_frame(b, stop, 1'b0);
            RX = 1'b1;
            idle(20);
            if ($urandom_range(0, 1) == 1) pulse_clr();
            idle(2);
            check_state("random");
        end

        // Back-to-back frames at N=868.
        baud_rx_sel = 3'b100;
        n = n_of(baud_rx_sel);
        send_frame(8'h00, 1'b1, n);
        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, n);
        model_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, n);
        model_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check_state("back-to-back");

        // Reset in the middle of a frame.
        fork
            send_frame(8'h96, 1'b1, n);
            begin
                idle(3000);
                chk("pre-reset busy", rx_busy, 1'b1);
                resetn = 1'b0;
                idle(1);
                chk("mid reset rx_data", rx_data, 8'h00);
                chk("mid reset rx_ready", rx_ready, 1'b0);
                chk("mid reset overrun", overrun, 1'b0);
                chk("mid reset rx_done", rx_done, 1'b0);
                chk("mid reset frame_err", frame_err, 1'b0);
                chk("mid reset rx_busy", rx_busy, 1'b0);
            end
        join
        RX = 1'b1;
        idle(5);
        resetn = 1'b1;
        exp_data    = 8'h00;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
        idle(10);
        check_state("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
